// File: rtl/csrng_pkg.sv
// Shared CSRNG types: application command encodings and the state-database
// write payload carried from the cmd/gen paths to the database.
package csrng_pkg;

  localparam int unsigned StateIdW = 4;
  localparam int unsigned KeyLenW  = 256;
  localparam int unsigned BlkLenW  = 128;
  localparam int unsigned CtrLenW  = 32;
  localparam int unsigned CmdW     = 3;

  typedef enum logic [CmdW-1:0] {
    INV = 3'b000,
    INS = 3'b001,
    RES = 3'b010,
    GEN = 3'b011,
    UPD = 3'b100,
    UNI = 3'b101
  } acmd_e;

  typedef struct packed {
    logic [StateIdW-1:0] inst_id;
    logic                fips;
    acmd_e               ccmd;
    logic [KeyLenW-1:0]  key;
    logic [BlkLenW-1:0]  v;
    logic [CtrLenW-1:0]  res_ctr;
    logic                sts;
  } csrng_state_db_wr_t;

endpackage

// File: rtl/csrng_state_db_wr_buf.sv
// One-entry holding buffer for a pending state-database write.
// The payload is not reset; only the valid flag is.
module csrng_state_db_wr_buf
  import csrng_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               load_i,
  input  logic               free_i,
  input  csrng_state_db_wr_t data_i,
  output logic               valid_o,
  output csrng_state_db_wr_t data_o
);

  logic               valid_r;
  csrng_state_db_wr_t data_r;

  // Occupancy flag: load and free never coincide since load needs an empty entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r <= 1'b0;
    end else if (!enable_i) begin
      valid_r <= 1'b0;
    end else if (load_i) begin
      valid_r <= 1'b1;
    end else if (free_i) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      data_r <= data_i;
    end else begin
      data_r <= data_r;
    end
  end

  assign valid_o = valid_r;
  assign data_o  = data_r;

endmodule

// File: rtl/csrng_state_db_wr_arb.sv
// Round-robin write arbiter between the cmd and gen paths in front of the
// CSRNG state database, with outstanding-write tracking and status fan-out.
module csrng_state_db_wr_arb
  import csrng_pkg::*;
#(
  parameter int NApps   = 4,
  parameter int StateId = 4,
  parameter int KeyLen  = 256,
  parameter int BlkLen  = 128,
  parameter int CtrLen  = 32,
  parameter int Cmd     = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               src0_req_i,
  output logic               src0_rdy_o,
  input  logic [StateId-1:0] src0_inst_id_i,
  input  logic               src0_fips_i,
  input  logic [Cmd-1:0]     src0_ccmd_i,
  input  logic [KeyLen-1:0]  src0_key_i,
  input  logic [BlkLen-1:0]  src0_v_i,
  input  logic [CtrLen-1:0]  src0_res_ctr_i,
  input  logic               src0_sts_i,
  input  logic               src1_req_i,
  output logic               src1_rdy_o,
  input  logic [StateId-1:0] src1_inst_id_i,
  input  logic               src1_fips_i,
  input  logic [Cmd-1:0]     src1_ccmd_i,
  input  logic [KeyLen-1:0]  src1_key_i,
  input  logic [BlkLen-1:0]  src1_v_i,
  input  logic [CtrLen-1:0]  src1_res_ctr_i,
  input  logic               src1_sts_i,
  output logic               wr_req_o,
  input  logic               wr_rdy_i,
  output logic [StateId-1:0] wr_inst_id_o,
  output logic               wr_fips_o,
  output logic [Cmd-1:0]     wr_ccmd_o,
  output logic [KeyLen-1:0]  wr_key_o,
  output logic [BlkLen-1:0]  wr_v_o,
  output logic [CtrLen-1:0]  wr_res_ctr_o,
  output logic               wr_sts_o,
  input  logic               sts_ack_i,
  input  logic               sts_sts_i,
  input  logic [StateId-1:0] sts_id_i,
  output logic [NApps-1:0]   app_ack_o,
  output logic [NApps-1:0]   app_sts_o,
  output logic               err_o,
  output logic               idle_o
);

  csrng_state_db_wr_t src0_data_s, src1_data_s, buf0_data_s, buf1_data_s;
  csrng_state_db_wr_t grant_data_s, out_data_r, wr_data_s;
  logic buf0_valid_s, buf1_valid_s, out_valid_r, last_r;
  logic live_s, consume_s, grant_any_s, grant_sel_s, id_oob_s, cnt_err_s;
  logic [1:0] cnt_r, cnt_nxt_s;
  logic [NApps-1:0] app_ack_s, app_sts_s;

  assign src0_data_s = {src0_inst_id_i, src0_fips_i, src0_ccmd_i, src0_key_i,
                        src0_v_i, src0_res_ctr_i, src0_sts_i};
  assign src1_data_s = {src1_inst_id_i, src1_fips_i, src1_ccmd_i, src1_key_i,
                        src1_v_i, src1_res_ctr_i, src1_sts_i};

  // Outputs are quiet both in reset and while flushing.
  assign live_s     = enable_i && rst_ni;
  assign src0_rdy_o = live_s && !buf0_valid_s;
  assign src1_rdy_o = live_s && !buf1_valid_s;

  // grant_sel_s = 1 selects source 1; on a tie the source not granted last wins.
  assign consume_s    = out_valid_r && wr_rdy_i;
  assign grant_any_s  = enable_i && (!out_valid_r || consume_s) && (buf0_valid_s || buf1_valid_s);
  assign grant_sel_s  = (buf0_valid_s && buf1_valid_s) ? !last_r : buf1_valid_s;
  assign grant_data_s = grant_sel_s ? buf1_data_s : buf0_data_s;

  csrng_state_db_wr_buf u_buf0 (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (enable_i),
    .load_i   (src0_req_i && src0_rdy_o),
    .free_i   (grant_any_s && !grant_sel_s),
    .data_i   (src0_data_s),
    .valid_o  (buf0_valid_s),
    .data_o   (buf0_data_s)
  );

  csrng_state_db_wr_buf u_buf1 (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (enable_i),
    .load_i   (src1_req_i && src1_rdy_o),
    .free_i   (grant_any_s && grant_sel_s),
    .data_i   (src1_data_s),
    .valid_o  (buf1_valid_s),
    .data_o   (buf1_data_s)
  );

  // Output valid, last-grant pointer and outstanding counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_r <= 1'b0;
      last_r      <= 1'b1;
      cnt_r       <= 2'd0;
    end else if (!enable_i) begin
      out_valid_r <= 1'b0;
      last_r      <= 1'b1;
      cnt_r       <= 2'd0;
    end else begin
      out_valid_r <= grant_any_s ? 1'b1 : (consume_s ? 1'b0 : out_valid_r);
      last_r      <= grant_any_s ? grant_sel_s : last_r;
      cnt_r       <= cnt_nxt_s;
    end
  end

  // Output payload, refreshed only when a new write is granted.
  always_ff @(posedge clk_i) begin
    if (grant_any_s) begin
      out_data_r <= grant_data_s;
    end else begin
      out_data_r <= out_data_r;
    end
  end

  // Counter saturates at both ends and flags the over/underflow instead.
  always_comb begin
    cnt_nxt_s = cnt_r;
    cnt_err_s = 1'b0;
    if (consume_s && !sts_ack_i) begin
      if (cnt_r == 2'd3) begin
        cnt_err_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + 2'd1;
      end
    end else if (sts_ack_i && !consume_s) begin
      if (cnt_r == 2'd0) begin
        cnt_err_s = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r - 2'd1;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Status return fan-out to the per-instance ack/status vectors.
  always_comb begin
    app_ack_s = '0;
    app_sts_s = '0;
    for (int i = 0; i < NApps; i++) begin
      if (live_s && sts_ack_i && (int'(sts_id_i) == i)) begin
        app_ack_s[i] = 1'b1;
        app_sts_s[i] = sts_sts_i;
      end else begin
        app_ack_s[i] = 1'b0;
        app_sts_s[i] = 1'b0;
      end
    end
  end

  assign id_oob_s  = int'(sts_id_i) >= NApps;
  assign app_ack_o = app_ack_s;
  assign app_sts_o = app_sts_s;
  assign err_o     = live_s && ((sts_ack_i && id_oob_s) || cnt_err_s);
  assign idle_o    = !buf0_valid_s && !buf1_valid_s && !out_valid_r && (cnt_r == 2'd0);

  assign wr_req_o     = out_valid_r;
  assign wr_data_s    = out_valid_r ? out_data_r : '0;
  assign wr_inst_id_o = wr_data_s.inst_id;
  assign wr_fips_o    = wr_data_s.fips;
  assign wr_ccmd_o    = wr_data_s.ccmd;
  assign wr_key_o     = wr_data_s.key;
  assign wr_v_o       = wr_data_s.v;
  assign wr_res_ctr_o = wr_data_s.res_ctr;
  assign wr_sts_o     = wr_data_s.sts;

endmodule

// File: tb/tb_csrng_state_db_wr_arb.sv
// Self-checking bench for csrng_state_db_wr_arb: contention vector table,
// scoreboard of issued writes, and hand-written corner-case sequences.
module tb_csrng_state_db_wr_arb;
  import csrng_pkg::*;

  logic clk = 1'b0;
  logic rst_ni, enable_i, wr_rdy_i, sts_ack_i, sts_sts_i;
  logic [3:0] sts_id_i;
  logic src0_req_i, src1_req_i, src0_rdy_o, src1_rdy_o, wr_req_o, err_o, idle_o;
  csrng_state_db_wr_t p0, p1, act_w;
  logic [3:0] wr_inst_id_o;
  logic wr_fips_o, wr_sts_o;
  logic [2:0] wr_ccmd_o;
  logic [255:0] wr_key_o;
  logic [127:0] wr_v_o;
  logic [31:0] wr_res_ctr_o;
  logic [3:0] app_ack_o, app_sts_o;

  int checks = 0;
  int errors = 0;
  csrng_state_db_wr_t exp_q[$];
  csrng_state_db_wr_t ack_q[$];
  int cnt_m = 0;
  logic stall_v = 1'b0;
  csrng_state_db_wr_t held;

  typedef struct {
    logic [1:0]  req;
    logic [3:0]  id0;
    logic [3:0]  id1;
    logic [31:0] seed;
    logic        first;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  csrng_state_db_wr_arb dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i),
    .src0_req_i(src0_req_i), .src0_rdy_o(src0_rdy_o), .src0_inst_id_i(p0.inst_id),
    .src0_fips_i(p0.fips), .src0_ccmd_i(p0.ccmd), .src0_key_i(p0.key), .src0_v_i(p0.v),
    .src0_res_ctr_i(p0.res_ctr), .src0_sts_i(p0.sts),
    .src1_req_i(src1_req_i), .src1_rdy_o(src1_rdy_o), .src1_inst_id_i(p1.inst_id),
    .src1_fips_i(p1.fips), .src1_ccmd_i(p1.ccmd), .src1_key_i(p1.key), .src1_v_i(p1.v),
    .src1_res_ctr_i(p1.res_ctr), .src1_sts_i(p1.sts),
    .wr_req_o(wr_req_o), .wr_rdy_i(wr_rdy_i), .wr_inst_id_o(wr_inst_id_o),
    .wr_fips_o(wr_fips_o), .wr_ccmd_o(wr_ccmd_o), .wr_key_o(wr_key_o), .wr_v_o(wr_v_o),
    .wr_res_ctr_o(wr_res_ctr_o), .wr_sts_o(wr_sts_o),
    .sts_ack_i(sts_ack_i), .sts_sts_i(sts_sts_i), .sts_id_i(sts_id_i),
    .app_ack_o(app_ack_o), .app_sts_o(app_sts_o), .err_o(err_o), .idle_o(idle_o)
  );

  assign act_w = {wr_inst_id_o, wr_fips_o, wr_ccmd_o, wr_key_o, wr_v_o, wr_res_ctr_o, wr_sts_o};

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic csrng_state_db_wr_t mk(input logic [3:0] id, input logic [31:0] seed, input bit src);
    csrng_state_db_wr_t p;
    p.inst_id = id;
    p.fips    = seed[0];
    case (seed[2:1])
      2'd0:    p.ccmd = INS;
      2'd1:    p.ccmd = RES;
      2'd2:    p.ccmd = UPD;
      default: p.ccmd = UNI;
    endcase
    if (src) p.ccmd = GEN;
    p.key     = {8{seed ^ 32'h1111_0000}};
    p.v       = {4{~seed}};
    p.res_ctr = seed + 32'd1;
    p.sts     = seed[4];
    return p;
  endfunction

  // Scoreboard and per-cycle model of err_o / app_ack_o / counter.
  always @(negedge clk) begin
    logic issue, exp_err;
    logic [3:0] exp_ack;
    csrng_state_db_wr_t e;
    if (!rst_ni) begin
      cnt_m = 0;
      stall_v = 1'b0;
    end else begin
      issue = wr_req_o && wr_rdy_i;
      exp_ack = 4'd0;
      if (enable_i && sts_ack_i && sts_id_i < 4'd4) exp_ack[sts_id_i[1:0]] = 1'b1;
      exp_err = enable_i && ((sts_ack_i && sts_id_i >= 4'd4) ||
                             (sts_ack_i && !issue && cnt_m == 0) ||
                             (issue && !sts_ack_i && cnt_m == 3));
      chk("err_model", 512'(err_o), 512'(exp_err));
      chk("app_ack_model", 512'(app_ack_o), 512'(exp_ack));
      if (!wr_req_o) chk("payload_gated", 512'(act_w), 512'd0);
      if (stall_v && enable_i) begin
        chk("stall_req", 512'(wr_req_o), 512'd1);
        chk("stall_payload", 512'(act_w), 512'(held));
      end
      if (issue) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 512'(act_w), 512'd0);
          errors += (act_w == '0) ? 1 : 0;
        end else begin
          e = exp_q.pop_front();
          chk("write_payload", 512'(act_w), 512'(e));
          ack_q.push_back(act_w);
        end
      end
      stall_v = enable_i && wr_req_o && !wr_rdy_i;
      held = act_w;
      if (!enable_i) cnt_m = 0;
      else if (issue && !sts_ack_i && cnt_m != 3) cnt_m++;
      else if (sts_ack_i && !issue && cnt_m != 0) cnt_m--;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one accept cycle; expected writes are queued in issue order.
  task automatic send(input logic [1:0] req, input logic [3:0] id0, input logic [3:0] id1,
                      input logic [31:0] seed, input logic first);
    cyc();
    p0 = mk(id0, seed, 1'b0);
    p1 = mk(id1, seed ^ 32'h5a5a_0f0f, 1'b1);
    src0_req_i = req[0];
    src1_req_i = req[1];
    #1;
    if (req[0]) chk("src0_rdy", 512'(src0_rdy_o), 512'd1);
    if (req[1]) chk("src1_rdy", 512'(src1_rdy_o), 512'd1);
    if (req == 2'b11) begin
      exp_q.push_back(first ? p1 : p0);
      exp_q.push_back(first ? p0 : p1);
    end else begin
      exp_q.push_back(req[1] ? p1 : p0);
    end
    cyc();
    src0_req_i = 1'b0;
    src1_req_i = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !wr_req_o) break;
      cyc();
    end
    chk("drain_pending", 512'(exp_q.size()), 512'd0);
  endtask

  task automatic ack(input logic [3:0] id, input logic sts, input logic exp_err);
    logic [3:0] ea, es;
    cyc();
    sts_ack_i = 1'b1;
    sts_id_i = id;
    sts_sts_i = sts;
    #1;
    ea = 4'd0;
    es = 4'd0;
    if (id < 4'd4) begin
      ea[id[1:0]] = 1'b1;
      es[id[1:0]] = sts;
    end
    chk("app_ack", 512'(app_ack_o), 512'(ea));
    chk("app_sts", 512'(app_sts_o), 512'(es));
    chk("ack_err", 512'(err_o), 512'(exp_err));
    cyc();
    sts_ack_i = 1'b0;
  endtask

  task automatic ack_all();
    csrng_state_db_wr_t p;
    while (ack_q.size() > 0) begin
      p = ack_q.pop_front();
      ack(p.inst_id, p.sts, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    csrng_state_db_wr_t p;
    vecs[0] = '{2'b11, 4'd0, 4'd1, 32'h1234_5678, 1'b0};
    vecs[1] = '{2'b11, 4'd2, 4'd3, 32'h0bad_cafe, 1'b0};
    vecs[2] = '{2'b01, 4'd1, 4'd0, 32'h0000_0013, 1'b0};
    vecs[3] = '{2'b11, 4'd3, 4'd0, 32'hdead_beef, 1'b1};
    vecs[4] = '{2'b10, 4'd0, 4'd2, 32'h7777_0001, 1'b1};
    vecs[5] = '{2'b11, 4'd1, 4'd2, 32'h0f0f_1e1e, 1'b0};

    rst_ni = 1'b0; enable_i = 1'b1; wr_rdy_i = 1'b1;
    src0_req_i = 1'b0; src1_req_i = 1'b0;
    sts_ack_i = 1'b0; sts_sts_i = 1'b0; sts_id_i = 4'd0;
    p0 = '0; p1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_req", 512'(wr_req_o), 512'd0);
    chk("rst_rdy0", 512'(src0_rdy_o), 512'd0);
    chk("rst_rdy1", 512'(src1_rdy_o), 512'd0);
    chk("rst_app_ack", 512'(app_ack_o), 512'd0);
    chk("rst_app_sts", 512'(app_sts_o), 512'd0);
    chk("rst_err", 512'(err_o), 512'd0);
    chk("rst_idle", 512'(idle_o), 512'd1);
    rst_ni = 1'b1;

    // Contention / rotation table
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].req, vecs[i].id0, vecs[i].id1, vecs[i].seed, vecs[i].first);
      chk("lat_k1", 512'(wr_req_o), 512'd0);
      cyc();
      chk("lat_k2", 512'(wr_req_o), 512'd1);
      wait_empty(20);
      ack_all();
      chk("idle_after_vec", 512'(idle_o), 512'd1);
    end

    // Single write, inst_id 2, status 0
    send(2'b01, 4'd2, 4'd0, 32'h0000_0020, 1'b0);
    chk("single_k1", 512'(wr_req_o), 512'd0);
    cyc();
    chk("single_k2", 512'(wr_req_o), 512'd1);
    chk("single_id", 512'(wr_inst_id_o), 512'd2);
    wait_empty(20);
    chk("single_not_idle", 512'(idle_o), 512'd0);
    ack_q.delete();
    ack(4'd2, 1'b0, 1'b0);
    chk("single_idle", 512'(idle_o), 512'd1);

    // Backpressure: B(src1) wins after src0 was granted last, then A, then C
    wr_rdy_i = 1'b0;
    send(2'b11, 4'd1, 4'd2, 32'h0000_a0a0, 1'b1);
    send(2'b10, 4'd0, 4'd3, 32'h0000_c0c1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_rdy0", 512'(src0_rdy_o), 512'd0);
      chk("bp_rdy1", 512'(src1_rdy_o), 512'd0);
      chk("bp_req", 512'(wr_req_o), 512'd1);
    end
    wr_rdy_i = 1'b1;
    wait_empty(20);
    send(2'b01, 4'd3, 4'd0, 32'h0000_d00d, 1'b0);
    wait_empty(20);
    for (int i = 0; i < 4; i++) begin
      p = ack_q.pop_front();
      ack(p.inst_id, p.sts, (i == 3) ? 1'b1 : 1'b0);
    end
    chk("bp_idle", 512'(idle_o), 512'd1);

    // Error returns
    send(2'b01, 4'd0, 4'd0, 32'h0000_0e0e, 1'b0);
    wait_empty(20);
    ack_q.delete();
    ack(4'd5, 1'b1, 1'b1);
    ack(4'd1, 1'b0, 1'b1);
    chk("err_idle_cnt0", 512'(idle_o), 512'd1);

    // Flush with one outstanding write, both buffers and output full
    send(2'b01, 4'd3, 4'd0, 32'h0000_1111, 1'b0);
    wait_empty(20);
    ack_q.delete();
    wr_rdy_i = 1'b0;
    send(2'b11, 4'd1, 4'd2, 32'h0000_2222, 1'b1);
    send(2'b10, 4'd0, 4'd3, 32'h0000_3333, 1'b1);
    cyc();
    enable_i = 1'b0;
    sts_ack_i = 1'b1; sts_id_i = 4'd1; sts_sts_i = 1'b1;
    #1;
    chk("fl_rdy0", 512'(src0_rdy_o), 512'd0);
    chk("fl_rdy1", 512'(src1_rdy_o), 512'd0);
    chk("fl_app_ack", 512'(app_ack_o), 512'd0);
    chk("fl_err", 512'(err_o), 512'd0);
    exp_q.delete();
    ack_q.delete();
    cyc();
    enable_i = 1'b1;
    sts_ack_i = 1'b0;
    #1;
    chk("fl_wr_req", 512'(wr_req_o), 512'd0);
    chk("fl_idle", 512'(idle_o), 512'd1);
    wr_rdy_i = 1'b1;
    repeat (6) cyc();
    ack(4'd1, 1'b0, 1'b1);

    // Reset while a write is presented
    wr_rdy_i = 1'b0;
    send(2'b10, 4'd0, 4'd7, 32'h0000_4444, 1'b1);
    cyc();
    chk("mr_req_before", 512'(wr_req_o), 512'd1);
    rst_ni = 1'b0;
    #1;
    chk("mr_req_in_rst", 512'(wr_req_o), 512'd0);
    chk("mr_idle_in_rst", 512'(idle_o), 512'd1);
    exp_q.delete();
    cyc();
    cyc();
    rst_ni = 1'b1;
    wr_rdy_i = 1'b1;
    repeat (8) cyc();
    chk("mr_req_after", 512'(wr_req_o), 512'd0);
    chk("mr_idle_after", 512'(idle_o), 512'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
